// File: rtl/mem_handshake.sv
// mem_handshake: valid/ready memory port with LATENCY-cycle access into the pmem backing store.
// Optional MEM_RAND_DELAY_EN adds 0..7 LFSR-driven extra cycles per request.
`default_nettype none

package mem_handshake_pmem_pkg;
  // Backing store with the pmem_read/pmem_write call signatures of the DPI-C memory.
  logic [63:0] pmem [logic [63:0]];
  int unsigned pmem_write_count;

  function automatic logic [63:0] pmem_read(input logic [63:0] raddr);
    logic [63:0] a;
    a = raddr & ~64'h7;
    if (pmem.exists(a)) return pmem[a];
    return '0;
  endfunction

  function automatic void pmem_write(input logic [63:0] waddr, input logic [63:0] wdata,
                                     input logic [7:0] wmask);
    logic [63:0] a;
    logic [63:0] d;
    a = waddr & ~64'h7;
    d = pmem.exists(a) ? pmem[a] : 64'h0;
    for (int i = 0; i < 8; i++) begin
      if (wmask[i]) d[i*8 +: 8] = wdata[i*8 +: 8];
    end
    pmem[a] = d;
    pmem_write_count++;
  endfunction
endpackage

module mem_handshake #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [7:0]          r_cnt;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

  logic                w_accept;
  logic [7:0]          w_cnt_load;
  logic [63:0]         w_addr_al;

  assign req_ready = (r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready);
  assign w_accept  = req_valid && req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign w_addr_al = 64'(r_addr) & ~64'(DATA_W/8 - 1);

`ifdef MEM_RAND_DELAY_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;

  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_cnt_load = 8'(LATENCY - 1) + {5'd0, r_lfsr[2:0]};

  // The value in use at accept picks the extra delay; the LFSR then advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end
`else
  assign w_cnt_load = 8'(LATENCY - 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            if (r_wen) begin
              if (r_wmask != '0) begin
                mem_handshake_pmem_pkg::pmem_write(w_addr_al, 64'(r_wdata), 8'(r_wmask));
              end
              r_rsp_rdata <= '0;
            end else begin
              r_rsp_rdata <= DATA_W'(mem_handshake_pmem_pkg::pmem_read(w_addr_al));
            end
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Accept from IDLE or on the RESP handshake edge; overrides the IDLE return above.
      if (w_accept) begin
        r_wen   <= req_wen;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wmask <= req_wmask;
        r_cnt   <= w_cnt_load;
        r_state <= S_WAIT;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_handshake.sv
// Self-checking bench for mem_handshake: four instances (LATENCY 3,1,4,2) share one input bus, selected by sel.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_handshake;

  logic        clk = 1'b0;
  logic        rst_n;
  int          sel;
  logic        req_valid;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_ready;

  logic        rr_a [4];
  logic        rv_a [4];
  logic [63:0] rd_a [4];
  logic        req_ready;
  logic        rv;
  logic [63:0] rd;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_handshake #(
      .ADDR_W (64),
      .DATA_W (64),
      .LATENCY((g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 4 : 2)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid && (sel == g)),
      .req_ready(rr_a[g]),
      .req_wen  (req_wen),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .req_wmask(req_wmask),
      .rsp_valid(rv_a[g]),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rd_a[g])
    );
  end

  assign req_ready = rr_a[sel];
  assign rv        = rv_a[sel];
  assign rd        = rd_a[sel];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a request and returns one time unit after the edge that accepted it.
  task automatic send_req(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] mask, output bit ok);
    bit acc;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = mask;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      acc = req_ready;
      step();
      if (acc) ok = 1'b1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (rv !== 1'b1 && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    sel = 0; rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({rv, rd} !== {1'b0, 64'h0}) begin
      n_fail++; $display("FAIL reset_outputs: got valid=%b rdata=%h, want 0/0", rv, rd);
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b, want 1", req_ready);
    end
  endtask

  task automatic test_read_latency();
    bit ok;
    logic [63:0] exp;
    sel = 0; rsp_ready = 1'b1;
    step();
    mem_handshake_pmem_pkg::pmem_write(64'h8000_0000, 64'h1122334455667788, 8'hFF);
    sb_q.push_back(64'h1122334455667788);
    send_req(1'b0, 64'h8000_0000, '0, '0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rd_accept: timeout, want accept"); end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({rv, req_ready} !== 2'b00) begin
        n_fail++; $display("FAIL rd_wait_%0d: got valid/ready=%b%b, want 00", k, rv, req_ready);
      end
      step();
    end
    exp = sb_q.pop_front();
    n_tests++;
    if ({rv, rd, req_ready} !== {1'b1, exp, 1'b1}) begin
      n_fail++; $display("FAIL rd_resp: got valid=%b rdata=%h ready=%b, want 1 %h 1", rv, rd, req_ready, exp);
    end
    step();
    n_tests++;
    if (rv !== 1'b0) begin n_fail++; $display("FAIL rd_one_cycle: got valid=%b, want 0", rv); end
  endtask

  task automatic test_write_read();
    bit ok;
    int n;
    int unsigned wc;
    logic [63:0] exp;
    sel = 0; rsp_ready = 1'b1;
    wc = mem_handshake_pmem_pkg::pmem_write_count;
    sb_q.push_back(64'h0);
    send_req(1'b1, 64'h8000_0008, 64'hDEADBEEFCAFEF00D, 8'h0F, ok);
    wait_valid(n);
    exp = sb_q.pop_front();
    n_tests++;
    if (n != 3 || rd !== exp) begin
      n_fail++; $display("FAIL wr_resp: got lat=%0d rdata=%h, want 3 %h", n, rd, exp);
    end
    step();
    n_tests++;
    if (mem_handshake_pmem_pkg::pmem_write_count != wc + 1) begin
      n_fail++; $display("FAIL wr_count: got %0d writes, want %0d", mem_handshake_pmem_pkg::pmem_write_count - wc, 1);
    end
    sb_q.push_back(64'h00000000CAFEF00D);
    send_req(1'b0, 64'h8000_0008, '0, '0, ok);
    wait_valid(n);
    exp = sb_q.pop_front();
    n_tests++;
    if (n != 3 || rd !== exp) begin
      n_fail++; $display("FAIL wr_readback: got lat=%0d rdata=%h, want 3 %h", n, rd, exp);
    end
    step();
  endtask

  task automatic test_boundaries();
    bit ok;
    int n;
    int unsigned wc;
    logic [63:0] exp;
    sel = 0; rsp_ready = 1'b1;
    wc = mem_handshake_pmem_pkg::pmem_write_count;
    sb_q.push_back(64'h0);
    send_req(1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, ok);
    wait_valid(n);
    exp = sb_q.pop_front();
    n_tests++;
    if (n != 3 || rd !== exp) begin
      n_fail++; $display("FAIL mask0_resp: got lat=%0d rdata=%h, want 3 %h", n, rd, exp);
    end
    step();
    n_tests++;
    if (mem_handshake_pmem_pkg::pmem_write_count != wc) begin
      n_fail++; $display("FAIL mask0_no_write: got %0d writes, want 0", mem_handshake_pmem_pkg::pmem_write_count - wc);
    end
    sb_q.push_back(64'h1122334455667788);
    send_req(1'b0, 64'h8000_0005, '0, '0, ok);
    wait_valid(n);
    exp = sb_q.pop_front();
    n_tests++;
    if (n != 3 || rd !== exp) begin
      n_fail++; $display("FAIL unaligned_rd: got lat=%0d rdata=%h, want 3 %h", n, rd, exp);
    end
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    logic [63:0] exp;
    sel = 0; rsp_ready = 1'b0;
    step();
    sb_q.push_back(64'h00000000CAFEF00D);
    send_req(1'b0, 64'h8000_0008, '0, '0, ok);
    wait_valid(n);
    exp = sb_q.pop_front();
    n_tests++;
    if (n != 3 || rd !== exp) begin
      n_fail++; $display("FAIL bp_resp: got lat=%0d rdata=%h, want 3 %h", n, rd, exp);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if ({rv, rd, req_ready} !== {1'b1, exp, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold_%0d: got valid=%b rdata=%h ready=%b, want 1 %h 0", k, rv, rd, req_ready, exp);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_comb: got %b, want 1", req_ready); end
    step();
    n_tests++;
    if (rv !== 1'b0) begin n_fail++; $display("FAIL bp_handshake: got valid=%b, want 0", rv); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    sel = 1; rsp_ready = 1'b1;
    step();
    mem_handshake_pmem_pkg::pmem_write(64'h8000_0010, 64'h0B0B_0B0B_0B0B_0B0B, 8'hFF);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0000;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ready: got %b, want 1", req_ready); end
    sb_q.push_back(64'h1122334455667788);
    step();
    req_addr = 64'h8000_0010;
    n_tests++;
    if ({rv, req_ready} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_wait_a: got valid/ready=%b%b, want 00", rv, req_ready);
    end
    step();
    exp = sb_q.pop_front();
    n_tests++;
    if ({rv, rd, req_ready} !== {1'b1, exp, 1'b1}) begin
      n_fail++; $display("FAIL b2b_resp_a: got valid=%b rdata=%h ready=%b, want 1 %h 1", rv, rd, req_ready, exp);
    end
    sb_q.push_back(64'h0B0B_0B0B_0B0B_0B0B);
    step();
    req_valid = 1'b0;
    n_tests++;
    if ({rv, req_ready} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_accept_b: got valid/ready=%b%b, want 00", rv, req_ready);
    end
    step();
    exp = sb_q.pop_front();
    n_tests++;
    if ({rv, rd} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL b2b_resp_b: got valid=%b rdata=%h, want 1 %h", rv, rd, exp);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int n;
    int unsigned wc;
    logic [63:0] exp;
    sel = 2; rsp_ready = 1'b0;
    step();
    sb_q.push_back(64'h1122334455667788);
    send_req(1'b0, 64'h8000_0000, '0, '0, ok);
    wait_valid(n);
    exp = sb_q.pop_front();
    n_tests++;
    if (n != 4 || rd !== exp) begin
      n_fail++; $display("FAIL rst_pre_resp: got lat=%0d rdata=%h, want 4 %h", n, rd, exp);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rv, rd, req_ready} !== {1'b0, 64'h0, 1'b1}) begin
      n_fail++; $display("FAIL rst_in_resp: got valid=%b rdata=%h ready=%b, want 0 0 1", rv, rd, req_ready);
    end
    step();
    rst_n = 1'b1; rsp_ready = 1'b1;
    step();
    wc = mem_handshake_pmem_pkg::pmem_write_count;
    send_req(1'b1, 64'h8000_0020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, ok);
    step();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({rv, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_in_wait: got valid/ready=%b%b, want 01", rv, req_ready);
    end
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (rv !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen || req_ready !== 1'b1 || mem_handshake_pmem_pkg::pmem_write_count != wc
        || mem_handshake_pmem_pkg::pmem_read(64'h8000_0020) !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_discard: got late_valid=%b ready=%b writes=%0d mem=%h, want 0 1 0 0", seen, req_ready,
               mem_handshake_pmem_pkg::pmem_write_count - wc, mem_handshake_pmem_pkg::pmem_read(64'h8000_0020));
    end
  endtask

  task automatic test_rand_delay();
    bit ok;
    int n;
    int exp_lat;
    logic [7:0] lfsr;
    logic [63:0] exp;
    sel = 3; rsp_ready = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    lfsr = 8'hA5;
`ifdef MEM_RAND_DELAY_EN
    for (int i = 0; i < 16; i++) begin
`else
    for (int i = 0; i < 2; i++) begin
`endif
`ifdef MEM_RAND_DELAY_EN
      exp_lat = 2 + int'(lfsr[2:0]);
`else
      exp_lat = 2;
`endif
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      sb_q.push_back((i % 2 == 0) ? 64'h1122334455667788 : 64'h0B0B_0B0B_0B0B_0B0B);
      send_req(1'b0, (i % 2 == 0) ? 64'h8000_0000 : 64'h8000_0010, '0, '0, ok);
      wait_valid(n);
      exp = sb_q.pop_front();
      n_tests++;
      if (n != exp_lat || rd !== exp) begin
        n_fail++; $display("FAIL lat_%0d: got lat=%0d rdata=%h, want %0d %h", i, n, rd, exp_lat, exp);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_read();
    test_boundaries();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_rand_delay();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_handshake.md
# mem_handshake

Clocked, parametrised successor to the combinational DPI memory port of the NPC core. It accepts one read or write request at a time over a valid/ready channel and calls `pmem_read`/`pmem_write` after a configurable latency. It returns the result over a second valid/ready channel. It sits between the IFU/LSU and the DPI-C backing memory, and models a real memory with non-zero latency and backpressure.

## Interface
- `ADDR_W`, 64: request address width, 32..64.
- `DATA_W`, 64: data width, 32 or 64; mask width is `DATA_W/8`.
- `LATENCY`, 1: cycles from request acceptance to `rsp_valid`, 1..255.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_wen`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  write data.
- `req_wmask`  in  DATA_W/8  byte-enable mask.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  DATA_W  read data; 0 for write responses.

## Operation
- FSM states:
  - IDLE: reset state.
  - WAIT: latency countdown.
  - RESP: response held.
- `req_ready` = (state==IDLE) | (state==RESP & rsp_ready). This is combinational from state and `rsp_ready`.
- Accept occurs on an edge with `req_valid & req_ready`:
  - latch wen, addr, wdata and mask;
  - load the 8-bit counter with `LATENCY-1` (plus extra delay, see Configuration);
  - go to WAIT.
- WAIT, each edge:
  - if counter==0: execute the DPI access, register the result into `rsp_rdata`, go to RESP;
  - otherwise decrement the counter.
- DPI access rules:
  - The address is aligned down to `DATA_W/8` bytes and zero-extended to 64 bits.
  - Read: `pmem_read`; the low `DATA_W` bits go to `rsp_rdata`.
  - Write: `pmem_write` with wdata zero-extended and mask zero-extended to 8 bits; `rsp_rdata` is set to 0.
  - A write with mask==0 skips `pmem_write` but still produces a response.
- RESP behaviour:
  - `rsp_valid`=1; `rsp_rdata` is held stable until `rsp_ready`.
  - On an edge with `rsp_ready`, go to IDLE. If `req_valid` is also high on that edge, go directly to WAIT with the new request latched (back-to-back).
- Exactly one DPI call per accepted request, never at the accept edge itself.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, counter 0. `req_ready`=1 after reset is released.
- Accept at edge E0 gives `rsp_valid` high after edge E(LATENCY). The DPI call occurs at that same edge.
- Best throughput with `rsp_ready` held high is one request per `LATENCY+1` cycles.
- `rsp_valid` never drops without a handshake. Request inputs are ignored outside an accept edge.
- Reset mid-operation (WAIT or RESP):
  - immediate return to IDLE;
  - a pending DPI access that has not executed is discarded (no write occurs);
  - `rsp_valid` and `rsp_rdata` clear asynchronously.
- Counter arithmetic is 8-bit unsigned. `LATENCY-1` plus extra delay must not exceed 255; this is guaranteed when `LATENCY`≤248.

## Configuration
- Macro: `MEM_RAND_DELAY_EN`.
- Defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) is seeded to 0xA5 on reset and steps once per accepted request.
  - At accept, `lfsr[2:0]` (0..7) is added to the counter load value.
  - Responses arrive after `LATENCY`..`LATENCY+7` cycles, for stress-testing the IFU/LSU handshakes.
- Undefined: no LFSR; latency is exactly `LATENCY`.

## Test plan
- Read latency, `LATENCY`=3, macro off:
  - Stimulus: pmem[0x80000000]=0x1122334455667788; read 0x80000000 accepted at E0; `rsp_ready`=1.
  - Required: `rsp_valid` rises after E3 with `rsp_rdata`=0x1122334455667788 and lasts one cycle; `req_ready` is 0 during WAIT.
- Write then read:
  - Stimulus: write 0x80000008, wdata 0xDEADBEEFCAFEF00D, mask 0x0F; then read 0x80000008 (memory previously 0).
  - Required: write response carries `rsp_rdata`=0; the read returns 0x00000000CAFEF00D.
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 5 cycles after `rsp_valid` rises.
  - Required: `rsp_valid` and `rsp_rdata` stay stable; `req_ready`=0; handshake occurs on the first edge with `rsp_ready`=1.
- Back-to-back: `req_valid` held with reads A=0x80000000 and B=0x80000010, `rsp_ready`=1, `LATENCY`=1 -> B is accepted on the same edge as A's response handshake, and B's response follows 1 cycle later.
- Reset mid-operation: write to 0x80000020 accepted, `LATENCY`=4, `rst_n` low for 1 cycle during WAIT -> `rsp_valid`=0 immediately, memory at 0x80000020 unchanged, `req_ready`=1 after release.
- `MEM_RAND_DELAY_EN`: 16 reads with `LATENCY`=2 -> every latency is in 2..9 and the latency sequence matches the 0xA5-seeded LFSR model.
